// File: rtl/ls_pkg.sv
// Shared types and constants for the load/store byte sequencer.
// Holds the FSM state encoding and the per-state memory drive helper.
package ls_pkg;

    localparam int BYTE_W = 8;
    localparam int ADDR_W = 8;
    localparam int WORD_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_STEP = 8'd1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LO   = 2'b01,
        HI   = 2'b10,
        DONE = 2'b11
    } ls_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [BYTE_W-1:0] data;
    } mem_drive_t;

    // Memory-side values for a given state; the high byte address wraps modulo 256.
    function automatic mem_drive_t mem_drive(
        input ls_state_e         st,
        input logic [ADDR_W-1:0] addr,
        input logic [WORD_W-1:0] wdata,
        input logic              store
    );
        mem_drive_t d;
        d.we   = 1'b0;
        d.addr = addr;
        d.data = {BYTE_W{1'b0}};
        case (st)
            LO: begin
                d.we   = store;
                d.data = wdata[BYTE_W-1:0];
            end
            HI: begin
                d.we   = store;
                d.addr = addr + ADDR_STEP;
                d.data = wdata[WORD_W-1:BYTE_W];
            end
            default: begin
                d.we   = 1'b0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ls_sequencer.sv
// Byte-serial load/store sequencer: splits 8/16-bit accesses into little-endian byte cycles.
// Optional feature macro: LS_SEQUENCER_WRAP_FAULT_EN (adds Fault, rejects wide access at 8'hFF).
module ls_sequencer
    import ls_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Store,
    input  logic              Wide,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [WORD_W-1:0] WrData,
    input  logic [BYTE_W-1:0] MemRdData,
    output logic              MemWriteEn,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [BYTE_W-1:0] MemWrData,
    output logic [WORD_W-1:0] RdData,
    output logic              Busy,
`ifdef LS_SEQUENCER_WRAP_FAULT_EN
    output logic              Done,
    output logic              Fault
`else
    output logic              Done
`endif
);

    ls_state_e         state_r;
    ls_state_e         state_n_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_n_s;
    logic [WORD_W-1:0] wrdata_r;
    logic [WORD_W-1:0] wrdata_n_s;
    logic              store_r;
    logic              store_n_s;
    logic              wide_r;
    logic              wide_n_s;
    logic [WORD_W-1:0] rd_data_r;
    logic [WORD_W-1:0] rd_data_n_s;
    logic              accept_s;
    logic              fault_hit_s;
    mem_drive_t        drive_n_s;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [BYTE_W-1:0] mem_wdata_r;
    logic              busy_r;
    logic              done_r;

    // Request acceptance: only IDLE and DONE listen to Start.
    always_comb begin
        accept_s = 1'b0;
        case (state_r)
            IDLE:    accept_s = Start;
            DONE:    accept_s = Start;
            default: accept_s = 1'b0;
        endcase
    end

    // Wide access at the top address either wraps or is rejected, depending on build.
    always_comb begin
`ifdef LS_SEQUENCER_WRAP_FAULT_EN
        fault_hit_s = Wide && (Addr == {ADDR_W{1'b1}});
`else
        fault_hit_s = 1'b0;
`endif
    end

    // Next-state logic.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_n_s = fault_hit_s ? DONE : LO;
                end else begin
                    state_n_s = IDLE;
                end
            end
            LO: begin
                if (wide_r) begin
                    state_n_s = HI;
                end else begin
                    state_n_s = DONE;
                end
            end
            HI:   state_n_s = DONE;
            DONE: begin
                if (accept_s) begin
                    state_n_s = fault_hit_s ? DONE : LO;
                end else begin
                    state_n_s = IDLE;
                end
            end
            default: state_n_s = IDLE;
        endcase
    end

    // Request latch: the access runs only on the values captured at acceptance.
    always_comb begin
        addr_n_s   = addr_r;
        wrdata_n_s = wrdata_r;
        store_n_s  = store_r;
        wide_n_s   = wide_r;
        if (accept_s) begin
            addr_n_s   = Addr;
            wrdata_n_s = WrData;
            store_n_s  = Store;
            wide_n_s   = Wide;
        end else begin
            addr_n_s   = addr_r;
            wrdata_n_s = wrdata_r;
            store_n_s  = store_r;
            wide_n_s   = wide_r;
        end
    end

    // Load assembly: a narrow load zero-fills the upper byte when leaving LO.
    always_comb begin
        rd_data_n_s = rd_data_r;
        case (state_r)
            LO: begin
                if (!store_r) begin
                    rd_data_n_s = {(wide_r ? rd_data_r[WORD_W-1:BYTE_W] : 8'h00), MemRdData};
                end else begin
                    rd_data_n_s = rd_data_r;
                end
            end
            HI: begin
                if (!store_r) begin
                    rd_data_n_s = {MemRdData, rd_data_r[BYTE_W-1:0]};
                end else begin
                    rd_data_n_s = rd_data_r;
                end
            end
            default: rd_data_n_s = rd_data_r;
        endcase
    end

    // Outputs are computed from the next state so they can be registered without added latency.
    always_comb begin
        drive_n_s = mem_drive(state_n_s, addr_n_s, wrdata_n_s, store_n_s);
    end

    // State, request and output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r     <= IDLE;
            addr_r      <= 8'h00;
            wrdata_r    <= 16'h0000;
            store_r     <= 1'b0;
            wide_r      <= 1'b0;
            rd_data_r   <= 16'h0000;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 8'h00;
            mem_wdata_r <= 8'h00;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            addr_r      <= addr_n_s;
            wrdata_r    <= wrdata_n_s;
            store_r     <= store_n_s;
            wide_r      <= wide_n_s;
            rd_data_r   <= rd_data_n_s;
            mem_we_r    <= drive_n_s.we;
            mem_addr_r  <= drive_n_s.addr;
            mem_wdata_r <= drive_n_s.data;
            busy_r      <= (state_n_s == LO) || (state_n_s == HI);
            done_r      <= (state_n_s == DONE);
        end
    end

`ifdef LS_SEQUENCER_WRAP_FAULT_EN
    logic fault_r;

    // Fault accompanies the single DONE cycle of a rejected access.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= accept_s && fault_hit_s;
        end
    end

    assign Fault = fault_r;
`endif

    assign MemWriteEn = mem_we_r;
    assign MemAddress = mem_addr_r;
    assign MemWrData  = mem_wdata_r;
    assign RdData     = rd_data_r;
    assign Busy       = busy_r;
    assign Done       = done_r;

endmodule

// File: tb/tb_ls_sequencer.sv
// Self-checking bench for ls_sequencer: vector table with a scoreboard, plus hand sequences
// for back-to-back, ignored Start, and reset-abort. Honors LS_SEQUENCER_WRAP_FAULT_EN.
module tb_ls_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Store;
    logic        Wide;
    logic [7:0]  Addr;
    logic [15:0] WrData;
    logic [7:0]  MemRdData;
    logic        MemWriteEn;
    logic [7:0]  MemAddress;
    logic [7:0]  MemWrData;
    logic [15:0] RdData;
    logic        Busy;
    logic        Done;
`ifdef LS_SEQUENCER_WRAP_FAULT_EN
    logic        Fault;
`endif

    ls_sequencer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Store      (Store),
        .Wide       (Wide),
        .Addr       (Addr),
        .WrData     (WrData),
        .MemRdData  (MemRdData),
        .MemWriteEn (MemWriteEn),
        .MemAddress (MemAddress),
        .MemWrData  (MemWrData),
        .RdData     (RdData),
        .Busy       (Busy),
`ifdef LS_SEQUENCER_WRAP_FAULT_EN
        .Done       (Done),
        .Fault      (Fault)
`else
        .Done       (Done)
`endif
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    bit         mem_load;
    logic [15:0] model_rd;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            32'h20:  return 8'h34;
            32'h21:  return 8'h12;
            32'h30:  return 8'h77;
            default: return i[7:0] ^ 8'hA5;
        endcase
    endfunction

    // Data memory: combinational read, write on posedge.
    always @(posedge Clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
        end else if (MemWriteEn) begin
            mem[MemAddress] <= MemWrData;
        end
    end
    assign MemRdData = mem[MemAddress];

    typedef struct {
        logic        store;
        logic        wide;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } vec_t;

    typedef struct {
        int              lat;
        int              busy;
        logic [15:0]     rd;
        logic            fault;
        int              nwr;
        logic [1:0][7:0] wa;
        logic [1:0][7:0] wd;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model of one access; updates the reference memory and load register.
    task automatic predict(input vec_t v, output exp_t e);
        logic       fault;
        logic [7:0] a1;
        logic [7:0] lo;
        a1 = v.addr + 8'd1;
`ifdef LS_SEQUENCER_WRAP_FAULT_EN
        fault = v.wide && (v.addr == 8'hFF);
`else
        fault = 1'b0;
`endif
        e.fault = fault;
        e.nwr   = 0;
        e.wa    = '0;
        e.wd    = '0;
        if (fault) begin
            e.lat  = 1;
            e.busy = 0;
        end else begin
            e.lat  = v.wide ? 3 : 2;
            e.busy = v.wide ? 2 : 1;
            if (v.store) begin
                e.wa[0] = v.addr;
                e.wd[0] = v.wdata[7:0];
                ref_mem[v.addr] = v.wdata[7:0];
                e.nwr = 1;
                if (v.wide) begin
                    e.wa[1] = a1;
                    e.wd[1] = v.wdata[15:8];
                    ref_mem[a1] = v.wdata[15:8];
                    e.nwr = 2;
                end
            end else begin
                lo = ref_mem[v.addr];
                model_rd = v.wide ? {ref_mem[a1], lo} : {8'h00, lo};
            end
        end
        e.rd = model_rd;
    endtask

    // Drive one access from an idle negedge, observe it, and score it.
    task automatic run_access(input vec_t v);
        exp_t            e;
        exp_t            got;
        int              lat;
        int              busy;
        int              nwr;
        logic [1:0][7:0] wa;
        logic [1:0][7:0] wd;
        lat  = 0;
        busy = 0;
        nwr  = 0;
        wa   = '0;
        wd   = '0;
        predict(v, e);
        sb_q.push_back(e);
        Start  = 1'b1;
        Store  = v.store;
        Wide   = v.wide;
        Addr   = v.addr;
        WrData = v.wdata;
        @(posedge Clk);
        #1;
        Start  = 1'b0;
        Store  = ~v.store;
        Wide   = ~v.wide;
        Addr   = ~v.addr;
        WrData = ~v.wdata;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            if (MemWriteEn) begin
                if (nwr < 2) begin
                    wa[nwr] = MemAddress;
                    wd[nwr] = MemWrData;
                end
                nwr++;
            end
            if (Busy) busy++;
            if (Done) begin
                lat = k;
                break;
            end
        end
        got = sb_q.pop_front();
        check($sformatf("latency@%h", v.addr), lat, got.lat);
        check($sformatf("busy_cycles@%h", v.addr), busy, got.busy);
        check($sformatf("rddata@%h", v.addr), RdData, got.rd);
        check($sformatf("write_count@%h", v.addr), nwr, got.nwr);
        for (int i = 0; i < 2; i++) begin
            if (i < got.nwr && i < nwr) begin
                check($sformatf("write%0d_addr@%h", i, v.addr), wa[i], got.wa[i]);
                check($sformatf("write%0d_data@%h", i, v.addr), wd[i], got.wd[i]);
            end
        end
`ifdef LS_SEQUENCER_WRAP_FAULT_EN
        check($sformatf("fault@%h", v.addr), Fault, got.fault);
`endif
        @(negedge Clk);
        check("idle_done", Done, 1'b0);
        check("idle_busy", Busy, 1'b0);
        check("idle_we", MemWriteEn, 1'b0);
        check("idle_addr", MemAddress, v.addr);
        check("idle_wdata", MemWrData, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset    = 1'b1;
        Start    = 1'b0;
        Store    = 1'b0;
        Wide     = 1'b0;
        Addr     = 8'h00;
        WrData   = 16'h0000;
        mem_load = 1'b1;
        model_rd = 16'h0000;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);

        vecs[0]  = '{1'b1, 1'b0, 8'h10, 16'hBEEF};
        vecs[1]  = '{1'b0, 1'b1, 8'h20, 16'h1357};
        vecs[2]  = '{1'b0, 1'b0, 8'h30, 16'h2468};
        vecs[3]  = '{1'b1, 1'b1, 8'h40, 16'hCAFE};
        vecs[4]  = '{1'b0, 1'b1, 8'h40, 16'h0000};
        vecs[5]  = '{1'b1, 1'b0, 8'h41, 16'h0011};
        vecs[6]  = '{1'b0, 1'b0, 8'h41, 16'hFFFF};
        vecs[7]  = '{1'b1, 1'b1, 8'hFF, 16'hA55A};
        vecs[8]  = '{1'b0, 1'b1, 8'hFF, 16'h0000};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 16'h0000};
        vecs[10] = '{1'b0, 1'b1, 8'h10, 16'h0000};

        repeat (2) @(posedge Clk);
        #1;
        mem_load = 1'b0;
        @(negedge Clk);
        check("reset_we", MemWriteEn, 1'b0);
        check("reset_addr", MemAddress, 8'h00);
        check("reset_wdata", MemWrData, 8'h00);
        check("reset_rddata", RdData, 16'h0000);
        check("reset_busy", Busy, 1'b0);
        check("reset_done", Done, 1'b0);
`ifdef LS_SEQUENCER_WRAP_FAULT_EN
        check("reset_fault", Fault, 1'b0);
`endif
        Reset = 1'b0;
        @(negedge Clk);

        for (int n = 0; n < 11; n++) run_access(vecs[n]);

        // Start held high: second access follows DONE with no idle cycle.
        Start = 1'b1; Store = 1'b0; Wide = 1'b1; Addr = 8'h20; WrData = 16'h0000;
        @(negedge Clk);
        check("b2b_lo_busy", Busy, 1'b1);
        check("b2b_lo_addr", MemAddress, 8'h20);
        @(negedge Clk);
        check("b2b_hi_busy", Busy, 1'b1);
        check("b2b_hi_addr", MemAddress, 8'h21);
        @(negedge Clk);
        check("b2b_done1", Done, 1'b1);
        check("b2b_rd1", RdData, 16'h1234);
        Addr = 8'h30; Wide = 1'b0;
        @(negedge Clk);
        check("b2b_second_busy", Busy, 1'b1);
        check("b2b_second_done", Done, 1'b0);
        check("b2b_second_addr", MemAddress, 8'h30);
        Start = 1'b0;
        @(negedge Clk);
        check("b2b_done2", Done, 1'b1);
        check("b2b_rd2", RdData, 16'h0077);
        model_rd = 16'h0077;
        @(negedge Clk);
        check("b2b_idle_busy", Busy, 1'b0);
        check("b2b_idle_done", Done, 1'b0);

        // Start pulse during HI must not launch another access.
        Start = 1'b1; Store = 1'b1; Wide = 1'b1; Addr = 8'h60; WrData = 16'h3344;
        @(posedge Clk);
        #1;
        Start = 1'b0; Addr = 8'h70;
        @(negedge Clk);
        check("ign_lo_we", MemWriteEn, 1'b1);
        check("ign_lo_addr", MemAddress, 8'h60);
        check("ign_lo_data", MemWrData, 8'h44);
        @(negedge Clk);
        check("ign_hi_we", MemWriteEn, 1'b1);
        check("ign_hi_addr", MemAddress, 8'h61);
        check("ign_hi_data", MemWrData, 8'h33);
        Start = 1'b1; Store = 1'b1; Wide = 1'b0; Addr = 8'h70; WrData = 16'hFFFF;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        @(negedge Clk);
        check("ign_done", Done, 1'b1);
        check("ign_done_we", MemWriteEn, 1'b0);
        @(negedge Clk);
        check("ign_after_busy", Busy, 1'b0);
        check("ign_after_we", MemWriteEn, 1'b0);
        check("ign_after_addr", MemAddress, 8'h60);
        ref_mem[8'h60] = 8'h44;
        ref_mem[8'h61] = 8'h33;
        check("ign_mem60", mem[8'h60], ref_mem[8'h60]);
        check("ign_mem61", mem[8'h61], ref_mem[8'h61]);
        check("ign_mem70", mem[8'h70], ref_mem[8'h70]);

        // Reset in HI of a wide store: only the low byte lands.
        Start = 1'b1; Store = 1'b1; Wide = 1'b1; Addr = 8'h80; WrData = 16'h9988;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        @(negedge Clk);
        check("rst_lo_we", MemWriteEn, 1'b1);
        @(negedge Clk);
        check("rst_hi_addr", MemAddress, 8'h81);
        Reset = 1'b1;
        #1;
        check("rst_async_we", MemWriteEn, 1'b0);
        check("rst_async_busy", Busy, 1'b0);
        check("rst_async_done", Done, 1'b0);
        check("rst_async_rd", RdData, 16'h0000);
        check("rst_async_addr", MemAddress, 8'h00);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_mem80", mem[8'h80], 8'h88);
        check("rst_mem81", mem[8'h81], ref_mem[8'h81]);
        ref_mem[8'h80] = 8'h88;
        model_rd = 16'h0000;
        run_access('{1'b0, 1'b1, 8'h80, 16'h0000});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
